caliptra_lc_tx_handshake_sender: RTL

Sender side of a life-cycle multibit request/acknowledge handshake. Converts a single-bit level request into an lc_tx_t-encoded request (lc_req_o) for a remote receiver that double-synchronizes it, and waits for the receiver's lc_tx_t echo (lc_ack_i). lc_ack_i is synchronized internally. Provides timeout and protocol/encoding error detection with a sticky fail-safe error state. Used for clock-bypass / debug-enable style handshakes between the life-cycle controller and peripheral domains.

---
 rtl/caliptra_lc_tx_handshake_sender.sv | 162 ++++++++++++++++
 1 files changed

// File: rtl/caliptra_lc_tx_handshake_sender.sv
// Sender side of a life-cycle multibit req/ack handshake: level request in, lc_tx_t request out,
// lc_tx_t echo back through an optional 2-flop synchronizer, with sticky timeout/protocol errors.
module caliptra_lc_tx_handshake_sender #(
  parameter bit          AsyncOn       = 1'b1,
  parameter int unsigned TimeoutCycles = 1024
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       req_i,
  output logic       ack_o,
  output logic       busy_o,
  output logic [3:0] lc_req_o,
  input  logic [3:0] lc_ack_i,
  output logic       timeout_err_o,
  output logic       proto_err_o,
  output logic [2:0] state_o
);

  localparam logic [3:0] LcOn  = 4'b0101;
  localparam logic [3:0] LcOff = 4'b1010;

  localparam int unsigned CntW = (TimeoutCycles == 0) ? 1 : $clog2(TimeoutCycles + 1);
  localparam logic [CntW-1:0] CntLimit = CntW'((TimeoutCycles == 0) ? 0 : TimeoutCycles - 1);
  localparam logic [CntW-1:0] CntMax   = '1;

  typedef enum logic [2:0] {
    StIdle    = 3'd0,
    StReqOn   = 3'd1,
    StAckedOn = 3'd2,
    StRelOff  = 3'd3,
    StError   = 3'd4
  } state_e;

  logic [3:0] ack_s;

  generate
    if (AsyncOn) begin : g_sync
      logic [3:0] sync1_q, sync2_q;
      always_ff @(posedge clk_i) begin
        if (rst_i) begin
          sync1_q <= LcOff;
          sync2_q <= LcOff;
        end else begin
          sync1_q <= lc_ack_i;
          sync2_q <= sync1_q;
        end
      end
      assign ack_s = sync2_q;
    end else begin : g_nosync
      assign ack_s = lc_ack_i;
    end
  endgenerate

  state_e          state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic            inv_q, inv_d;
  logic            ack_q, ack_d;
  logic            busy_q, busy_d;
  logic [3:0]      req_q, req_d;
  logic            terr_q, terr_d;
  logic            perr_q, perr_d;

  logic   ack_invalid, enc_err, busy_state, exit_met, proto_hit, at_limit;
  state_e next_normal;

  always_comb begin
    ack_invalid = (ack_s != LcOn) && (ack_s != LcOff);
    inv_d       = ack_invalid;
    // One invalid sample is tolerated as async skew; two in a row is a fault.
    enc_err     = ack_invalid && inv_q;
    busy_state  = (state_q == StReqOn) || (state_q == StRelOff);
    at_limit    = (TimeoutCycles != 0) && (cnt_q == CntLimit);
    exit_met    = 1'b0;
    proto_hit   = 1'b0;
    next_normal = state_q;

    case (state_q)
      StIdle: begin
        proto_hit = (ack_s == LcOn);
        if (req_i) next_normal = StReqOn;
      end
      StReqOn: begin
        exit_met = (ack_s == LcOn);
        if (exit_met) next_normal = StAckedOn;
      end
      StAckedOn: begin
        proto_hit = (ack_s == LcOff);
        if (!req_i) next_normal = StRelOff;
      end
      StRelOff: begin
        exit_met = (ack_s == LcOff);
        if (exit_met) next_normal = StIdle;
      end
      default: next_normal = StError;
    endcase

    state_d = state_q;
    terr_d  = terr_q;
    perr_d  = perr_q;
    if (state_q != StError) begin
      if (enc_err) begin
        state_d = StError;
        perr_d  = 1'b1;
      end else if (busy_state && at_limit && !exit_met) begin
        state_d = StError;
        terr_d  = 1'b1;
      end else if (proto_hit) begin
        state_d = StError;
        perr_d  = 1'b1;
      end else begin
        state_d = next_normal;
      end
    end

    // Counter restarts on every entry into a waiting state and saturates while waiting.
    cnt_d = '0;
    if (busy_state && (state_d == state_q)) begin
      cnt_d = (cnt_q == CntMax) ? cnt_q : cnt_q + 1'b1;
    end

    req_d  = ((state_d == StReqOn) || (state_d == StAckedOn)) ? LcOn : LcOff;
    ack_d  = (state_d == StAckedOn);
    busy_d = (state_d == StReqOn) || (state_d == StRelOff);
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      inv_q   <= 1'b0;
      ack_q   <= 1'b0;
      busy_q  <= 1'b0;
      req_q   <= LcOff;
      terr_q  <= 1'b0;
      perr_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      inv_q   <= inv_d;
      ack_q   <= ack_d;
      busy_q  <= busy_d;
      req_q   <= req_d;
      terr_q  <= terr_d;
      perr_q  <= perr_d;
    end
  end

  assign ack_o         = ack_q;
  assign busy_o        = busy_q;
  assign lc_req_o      = req_q;
  assign timeout_err_o = terr_q;
  assign proto_err_o   = perr_q;
  assign state_o       = state_q;

  a_req_encoded: assert property (@(posedge clk_i) disable iff (rst_i)
    !$isunknown(lc_req_o) && ((lc_req_o == LcOn) || (lc_req_o == LcOff)));
  a_ack_busy_excl: assert property (@(posedge clk_i) disable iff (rst_i)
    !(ack_o && busy_o));
  a_timeout_param: assert property (@(posedge clk_i)
    (TimeoutCycles == 0) || (TimeoutCycles >= 8));

endmodule
